// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 16-bit ALU: owns the register file, issues
// one instruction at a time to the ALU and writes the captured result back.
module alu_issue_ctrl #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  output logic              illegal,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int NUM_REGS = 2 ** REG_AW;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_t;

  state_t            state;
  logic [15:0]       instr;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] regFile [NUM_REGS];

  logic [2:0]        op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic              unusedBit;

  assign op        = instr[15:13];
  assign rd        = REG_AW'(instr[12:9]);
  assign rs        = REG_AW'(instr[8:5]);
  assign rt        = REG_AW'(instr[4:1]);
  assign unusedBit = instr[0];

  // r0 is hard-wired to zero on every read path.
  function automatic logic [DATA_W-1:0] readReg(input logic [REG_AW-1:0] addr);
    return (addr == '0) ? '0 : regFile[addr];
  endfunction

  // NOTE: ready is gated by rst directly so it is low for the whole reset
  // window, not just after the first clock edge inside it.
  assign instr_ready = (state == IDLE) && !rst;
  assign done        = (state == WB);
  assign dbg_data    = readReg(dbg_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      instr   <= '0;
      result  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      illegal <= 1'b0;
      // NOTE: the register file is cleared on reset because software relies on
      // every register reading zero afterwards; this forces flops, not a RAM.
      for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr <= instr_data;
            state <= DECODE;
          end
        end
        DECODE: begin
          if (op <= 3'd3) begin
            alu_a  <= readReg(rs);
            alu_b  <= readReg(rt);
            alu_op <= op[1:0];
            state  <= EXEC;
          end else if (op == 3'd4) begin
            result <= DATA_W'(instr[7:0]);
            state  <= WB;
          end else begin
            illegal <= 1'b1;
            state   <= IDLE;
          end
        end
        EXEC: begin
          result <= alu_result;
          state  <= WB;
        end
        WB: begin
          if (rd != '0) regFile[rd] <= result;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios then random instructions, each
// checked against a register-array model and an ALU stub driven by the bench.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr_data = '0;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic [15:0] alu_result;
  logic        done;
  logic        illegal;
  logic [3:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  int errors = 0;
  int checks = 0;
  int hsCount = 0;
  int doneCount = 0;
  int expHs = 0;
  int expDone = 0;

  logic [15:0] mr [16];
  logic [15:0] lastA = '0;
  logic [15:0] lastB = '0;
  logic [1:0]  lastOp = '0;

  alu_issue_ctrl #(.DATA_W(16), .REG_AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_data (instr_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .done       (done),
    .illegal    (illegal),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] aluStub(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a + b;
      2'd2:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = aluStub(alu_op, alu_a, alu_b);

  always @(posedge clk) begin
    if (instr_valid && instr_ready) hsCount <= hsCount + 1;
    if (done) doneCount <= doneCount + 1;
  end

  function automatic logic [15:0] mkAlu(input logic [2:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt);
    return {op, rd, rs, rt, 1'b0};
  endfunction

  function automatic logic [15:0] mkLdi(input logic [3:0] rd, input logic [7:0] imm);
    return {3'd4, rd, 1'b0, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkReg(input int r);
    dbg_addr = 4'(r);
    #1;
    check($sformatf("dbg_r%0d", r), dbg_data, mr[r]);
  endtask

  task automatic checkAllRegs();
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      checkReg(r);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge where it is idle again.
  task automatic runInstr(input logic [15:0] w, input bit holdValid);
    logic [2:0]  op;
    logic [3:0]  rd, rs, rt;
    logic [15:0] ea, eb, res;
    op = w[15:13];
    rd = w[12:9];
    rs = w[8:5];
    rt = w[4:1];
    check("ready_idle", instr_ready, 1);
    instr_valid = 1'b1;
    instr_data  = w;
    @(posedge clk);
    expHs++;
    @(negedge clk);
    if (!holdValid) instr_valid = 1'b0;
    check("decode_ready", instr_ready, 0);
    check("decode_done", done, 0);
    check("decode_illegal", illegal, 0);
    @(negedge clk);
    if (op <= 3'd3) begin
      ea = (rs == 0) ? 16'h0 : mr[rs];
      eb = (rt == 0) ? 16'h0 : mr[rt];
      check("exec_alu_a", alu_a, ea);
      check("exec_alu_b", alu_b, eb);
      check("exec_alu_op", alu_op, op[1:0]);
      check("exec_done", done, 0);
      check("exec_ready", instr_ready, 0);
      lastA = ea;
      lastB = eb;
      lastOp = op[1:0];
      @(negedge clk);
      check("wb_done", done, 1);
      res = aluStub(op[1:0], ea, eb);
      if (rd != 0) mr[rd] = res;
      expDone++;
      @(negedge clk);
      check("post_done", done, 0);
      check("post_ready", instr_ready, 1);
      checkReg(rd);
    end else if (op == 3'd4) begin
      check("ldi_done", done, 1);
      check("ldi_ready", instr_ready, 0);
      if (rd != 0) mr[rd] = {8'h00, w[7:0]};
      expDone++;
      @(negedge clk);
      check("ldi_post_done", done, 0);
      check("ldi_post_ready", instr_ready, 1);
      checkReg(rd);
    end else begin
      check("illegal_pulse", illegal, 1);
      check("illegal_ready", instr_ready, 1);
      check("illegal_done", done, 0);
    end
    check("hold_alu_a", alu_a, lastA);
    check("hold_alu_b", alu_b, lastB);
    check("hold_alu_op", alu_op, lastOp);
    check("handshakes", hsCount, expHs);
    check("done_count", doneCount, expDone);
  endtask

  initial begin
    logic [15:0] w;
    for (int r = 0; r < 16; r++) mr[r] = '0;

    // Reset from power-up.
    #2 rst = 1'b1;
    #1;
    check("rst_ready", instr_ready, 0);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_op", alu_op, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release_ready", instr_ready, 1);
    checkAllRegs();

    // LDI pair, then r5 = r3 + r4.
    @(negedge clk);
    runInstr(mkLdi(4'd3, 8'h23), 1'b0);
    runInstr(mkLdi(4'd4, 8'h05), 1'b0);
    runInstr(mkAlu(3'd1, 4'd5, 4'd3, 4'd4), 1'b0);
    dbg_addr = 4'd5;
    #1 check("r5_is_0028", dbg_data, 16'h0028);

    // r0 stays zero and reads back as zero into the ALU.
    runInstr(mkLdi(4'd0, 8'hFF), 1'b0);
    runInstr(mkAlu(3'd1, 4'd6, 4'd0, 4'd4), 1'b0);

    // Illegal opcode leaves every register untouched.
    runInstr({3'd6, 4'd3, 4'd3, 4'd4, 1'b0}, 1'b0);
    @(negedge clk);
    check("illegal_cleared", illegal, 0);
    checkAllRegs();

    // Back-to-back with valid held high, including rd == rs.
    @(negedge clk);
    runInstr(mkAlu(3'd1, 4'd5, 4'd5, 4'd4), 1'b1);
    runInstr(mkLdi(4'd7, 8'h11), 1'b1);
    runInstr(mkAlu(3'd2, 4'd8, 4'd5, 4'd7), 1'b0);
    dbg_addr = 4'd5;
    #1 check("r5_is_002d", dbg_data, 16'h002D);

    // Reset in the middle of EXEC discards the instruction.
    @(negedge clk);
    instr_valid = 1'b1;
    instr_data  = mkAlu(3'd1, 4'd9, 4'd5, 4'd4);
    @(posedge clk);
    expHs++;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_alu_a", alu_a, mr[5]);
    #2 rst = 1'b1;
    #1;
    check("midrst_alu_a", alu_a, 0);
    check("midrst_alu_b", alu_b, 0);
    check("midrst_alu_op", alu_op, 0);
    check("midrst_done", done, 0);
    check("midrst_illegal", illegal, 0);
    check("midrst_ready", instr_ready, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 16; r++) mr[r] = '0;
    lastA = '0;
    lastB = '0;
    lastOp = '0;
    #1 check("midrst_release_ready", instr_ready, 1);
    repeat (4) @(negedge clk);
    check("midrst_no_done", doneCount, expDone);
    check("midrst_handshakes", hsCount, expHs);
    checkAllRegs();

    // Random instruction stream.
    @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 2) == 0) w[15:13] = 3'd4;
      runInstr(w, (n != 39) && ($urandom_range(0, 1) == 1));
    end
    checkAllRegs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
